axis_input_sync: RTL and testbench

- Generalised successor to the conv-engine input joiner.
- Merges N independently handshaked pixel streams (COPIES = 1..4) and one weights stream into a single lock-step beat for the conv engine.
- Each input gets its own elastic FIFO and its own tready, where the previous block shared one pixel ready. Adds a registered output stage, a weights-only config-beat bypass, and a cross-copy tuser consistency check.
- Sits between the image shift buffers / weight rotator and the conv engine.

---
 rtl/axis_input_sync_if.sv | 52 +++++
 rtl/axis_input_sync.sv | 211 +++++++++++++++++++++
 tb/tb_axis_input_sync.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_input_sync_if.sv
// ============================================================================
// Module : axis_input_sync_if
// Brief  : Stream bundle for the conv-engine input joiner: N pixel streams,
//          one weights stream and the joined output stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axis_input_sync_if #(
    parameter int COPIES     = 2,
    parameter int PIX_W      = 64,
    parameter int W_W        = 256,
    parameter int PIX_USER_W = 8,
    parameter int W_USER_W   = 8
);
    logic [COPIES-1:0]            s_axis_pixels_tvalid;
    logic [COPIES-1:0]            s_axis_pixels_tready;
    logic [COPIES*PIX_W-1:0]      s_axis_pixels_tdata;
    logic [COPIES*PIX_USER_W-1:0] s_axis_pixels_tuser;
    logic                         s_axis_weights_tvalid;
    logic                         s_axis_weights_tready;
    logic                         s_axis_weights_tlast;
    logic [W_W-1:0]               s_axis_weights_tdata;
    logic [W_USER_W-1:0]          s_axis_weights_tuser;
    logic                         m_axis_tvalid;
    logic                         m_axis_tready;
    logic                         m_axis_tlast;
    logic [COPIES*PIX_W-1:0]      m_axis_pixels_tdata;
    logic [W_W-1:0]               m_axis_weights_tdata;
    logic [PIX_USER_W+W_USER_W-1:0] m_axis_tuser;

    // slave: the joiner itself; master: the surrounding producers/consumer
    modport slave (
        input  s_axis_pixels_tvalid, s_axis_pixels_tdata, s_axis_pixels_tuser,
        input  s_axis_weights_tvalid, s_axis_weights_tlast, s_axis_weights_tdata,
        input  s_axis_weights_tuser, m_axis_tready,
        output s_axis_pixels_tready, s_axis_weights_tready,
        output m_axis_tvalid, m_axis_tlast, m_axis_pixels_tdata, m_axis_weights_tdata,
        output m_axis_tuser
    );

    modport master (
        output s_axis_pixels_tvalid, s_axis_pixels_tdata, s_axis_pixels_tuser,
        output s_axis_weights_tvalid, s_axis_weights_tlast, s_axis_weights_tdata,
        output s_axis_weights_tuser, m_axis_tready,
        input  s_axis_pixels_tready, s_axis_weights_tready,
        input  m_axis_tvalid, m_axis_tlast, m_axis_pixels_tdata, m_axis_weights_tdata,
        input  m_axis_tuser
    );
endinterface

`default_nettype wire

// File: rtl/axis_input_sync.sv
// ============================================================================
// Module : axis_input_sync
// Brief  : Joins COPIES pixel streams and one weights stream into a lock-step
//          beat through per-input FIFOs and a registered output stage.
//          Optional AXIS_INPUT_SYNC_STALL_COUNTERS_EN adds stall_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_input_sync #(
    parameter int                  COPIES           = 2,
    parameter int                  PIX_W            = 64,
    parameter int                  W_W              = 256,
    parameter int                  PIX_USER_W       = 8,
    parameter int                  W_USER_W         = 8,
    parameter int                  FIFO_DEPTH       = 4,
    parameter logic [W_USER_W-1:0] W_USER_GATE_MASK = 8'b0001_0111,
    parameter int                  W_CONFIG_BIT     = 3
) (
    input  wire               aclk,
    input  wire               areset,
    axis_input_sync_if.slave  bus,
    output logic              err_user_mismatch
`ifdef AXIS_INPUT_SYNC_STALL_COUNTERS_EN
    ,
    output logic [(COPIES+2)*32-1:0] stall_count
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_WE_W  = W_W + W_USER_W + 1;

    logic [COPIES-1:0]            w_pix_ne;
    logic [COPIES*PIX_W-1:0]      w_pix_head_d;
    logic [COPIES*PIX_USER_W-1:0] w_pix_head_u;
    logic                         w_w_ne;
    logic [c_WE_W-1:0]            w_w_head;
    logic                         w_out_free;
    logic                         w_fire_norm;
    logic                         w_fire_cfg;
    logic                         w_w_pop;

    logic                         r_mvalid;
    logic                         r_mlast;
    logic [COPIES*PIX_W-1:0]      r_pdata;
    logic [PIX_USER_W-1:0]        r_puser;
    logic [W_W-1:0]               r_wdata;
    logic [W_USER_W-1:0]          r_wuser;

    // ---------------------------------------------------------------- pixel FIFOs
    for (genvar k = 0; k < COPIES; k++) begin : g_pix
        logic [PIX_W+PIX_USER_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]          r_wp;
        logic [c_PTR_W-1:0]          r_rp;
        logic [c_CNT_W-1:0]          r_cnt;
        logic [c_CNT_W-1:0]          w_cnt_nxt;
        logic                        r_rdy;
        logic                        w_wr;

        assign w_wr      = bus.s_axis_pixels_tvalid[k] && r_rdy;
        assign w_cnt_nxt = r_cnt + c_CNT_W'(w_wr) - c_CNT_W'(w_fire_norm);

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_rdy <= 1'b0;
            end else begin
                if (w_wr)        r_wp <= r_wp + 1'b1;
                if (w_fire_norm) r_rp <= r_rp + 1'b1;
                r_cnt <= w_cnt_nxt;
                r_rdy <= (w_cnt_nxt < c_CNT_W'(FIFO_DEPTH));
            end
        end

        always_ff @(posedge aclk) begin
            if (w_wr) begin
                r_mem[r_wp] <= {bus.s_axis_pixels_tuser[k*PIX_USER_W +: PIX_USER_W],
                                bus.s_axis_pixels_tdata[k*PIX_W +: PIX_W]};
            end
        end

        assign bus.s_axis_pixels_tready[k]               = r_rdy;
        assign w_pix_ne[k]                               = (r_cnt != '0);
        assign w_pix_head_d[k*PIX_W +: PIX_W]            = r_mem[r_rp][PIX_W-1:0];
        assign w_pix_head_u[k*PIX_USER_W +: PIX_USER_W]  = r_mem[r_rp][PIX_W +: PIX_USER_W];
    end

    // -------------------------------------------------------------- weights FIFO
    logic [c_WE_W-1:0]  r_w_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_w_wp;
    logic [c_PTR_W-1:0] r_w_rp;
    logic [c_CNT_W-1:0] r_w_cnt;
    logic [c_CNT_W-1:0] w_w_cnt_nxt;
    logic               r_w_rdy;
    logic               w_w_wr;

    assign w_w_wr      = bus.s_axis_weights_tvalid && r_w_rdy;
    assign w_w_cnt_nxt = r_w_cnt + c_CNT_W'(w_w_wr) - c_CNT_W'(w_w_pop);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_w_wp  <= '0;
            r_w_rp  <= '0;
            r_w_cnt <= '0;
            r_w_rdy <= 1'b0;
        end else begin
            if (w_w_wr)  r_w_wp <= r_w_wp + 1'b1;
            if (w_w_pop) r_w_rp <= r_w_rp + 1'b1;
            r_w_cnt <= w_w_cnt_nxt;
            r_w_rdy <= (w_w_cnt_nxt < c_CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge aclk) begin
        if (w_w_wr) begin
            r_w_mem[r_w_wp] <= {bus.s_axis_weights_tlast, bus.s_axis_weights_tuser,
                                bus.s_axis_weights_tdata};
        end
    end

    assign bus.s_axis_weights_tready = r_w_rdy;
    assign w_w_ne                    = (r_w_cnt != '0);
    assign w_w_head                  = r_w_mem[r_w_rp];

    // ------------------------------------------------------------ join control
    // A config beat at the weights head never waits for pixels.
    assign w_out_free  = !r_mvalid || bus.m_axis_tready;
    assign w_fire_cfg  = w_w_ne && w_w_head[W_W + W_CONFIG_BIT] && w_out_free;
    assign w_fire_norm = w_w_ne && !w_w_head[W_W + W_CONFIG_BIT] && (&w_pix_ne) && w_out_free;
    assign w_w_pop     = w_fire_norm || w_fire_cfg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
            r_pdata  <= '0;
            r_puser  <= '0;
            r_wdata  <= '0;
            r_wuser  <= '0;
        end else if (w_w_pop) begin
            r_mvalid <= 1'b1;
            r_mlast  <= w_w_head[c_WE_W-1];
            r_pdata  <= w_fire_norm ? w_pix_head_d : '0;
            r_puser  <= w_fire_norm ? w_pix_head_u[PIX_USER_W-1:0] : '0;
            r_wdata  <= w_w_head[W_W-1:0];
            r_wuser  <= w_w_head[W_W +: W_USER_W];
        end else if (bus.m_axis_tready) begin
            r_mvalid <= 1'b0;
        end
    end

    assign bus.m_axis_tvalid        = r_mvalid;
    assign bus.m_axis_tlast         = r_mlast;
    assign bus.m_axis_pixels_tdata  = r_pdata;
    assign bus.m_axis_weights_tdata = r_wdata;
    assign bus.m_axis_tuser         = {r_wuser & (~W_USER_GATE_MASK | {W_USER_W{r_mvalid}}),
                                       r_puser};

    // ------------------------------------------------------ tuser consistency
    if (COPIES > 1) begin : g_chk
        logic w_mm;
        logic r_err;

        always_comb begin
            w_mm = 1'b0;
            for (int k = 1; k < COPIES; k++) begin
                if (w_pix_head_u[k*PIX_USER_W +: PIX_USER_W] != w_pix_head_u[PIX_USER_W-1:0])
                    w_mm = 1'b1;
            end
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset)                  r_err <= 1'b0;
            else if (w_fire_norm && w_mm) r_err <= 1'b1;
        end

        assign err_user_mismatch = r_err;
    end else begin : g_nochk
        assign err_user_mismatch = 1'b0;
    end

`ifdef AXIS_INPUT_SYNC_STALL_COUNTERS_EN
    // ------------------------------------------------------- stall statistics
    logic [COPIES:0] w_ne_all;
    assign w_ne_all = {w_w_ne, w_pix_ne};

    for (genvar i = 0; i < COPIES + 2; i++) begin : g_stall
        logic        w_inc;
        logic [31:0] r_c;

        if (i <= COPIES) begin : g_in
            assign w_inc = !w_ne_all[i] && (|w_ne_all);
        end else begin : g_out
            assign w_inc = r_mvalid && !bus.m_axis_tready;
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset)                        r_c <= '0;
            else if (w_inc && (r_c != '1))     r_c <= r_c + 32'd1;
        end

        assign stall_count[i*32 +: 32] = r_c;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_input_sync.sv
// ============================================================================
// Module : tb_axis_input_sync
// Brief  : Scoreboard bench for axis_input_sync: directed scenarios plus
//          randomized traffic against a queue-based join model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_input_sync;

    localparam int         COPIES = 2;
    localparam int         PIX_W  = 64;
    localparam int         W_W    = 256;
    localparam int         PU     = 8;
    localparam int         WU     = 8;
    localparam logic [7:0] MASK   = 8'h17;

    typedef struct packed { logic [63:0] d; logic [7:0] u; } pix_t;
    typedef struct packed { logic [255:0] d; logic [7:0] u; logic l; } wt_t;
    typedef struct packed {
        logic [127:0] pd; logic [255:0] wd; logic l; logic [15:0] tu; logic err;
    } beat_t;

    logic aclk = 1'b0;
    logic areset;
    logic err;
`ifdef AXIS_INPUT_SYNC_STALL_COUNTERS_EN
    logic [(COPIES+2)*32-1:0] stall_count;
`endif

    axis_input_sync_if #(.COPIES(COPIES), .PIX_W(PIX_W), .W_W(W_W),
                         .PIX_USER_W(PU), .W_USER_W(WU)) bus ();

    axis_input_sync #(.COPIES(COPIES), .PIX_W(PIX_W), .W_W(W_W), .PIX_USER_W(PU),
                      .W_USER_W(WU), .FIFO_DEPTH(4), .W_USER_GATE_MASK(MASK),
                      .W_CONFIG_BIT(3)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .bus               (bus),
        .err_user_mismatch (err)
`ifdef AXIS_INPUT_SYNC_STALL_COUNTERS_EN
        ,
        .stall_count       (stall_count)
`endif
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    pix_t  pq0[$];
    pix_t  pq1[$];
    wt_t   wq[$];
    beat_t expq[$];
    logic  err_model;

    logic [1:0] acc_p;
    logic       acc_w;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; a valid that was not yet accepted is held.
    task automatic tick(input logic [1:0] want_p, input logic want_w, input logic mrdy,
                        input logic [7:0] pu0, input logic [7:0] pu1, input logic [7:0] wu);
        logic [255:0] v;
        for (int k = 0; k < COPIES; k++) begin
            if (!(bus.s_axis_pixels_tvalid[k] && !acc_p[k])) begin
                bus.s_axis_pixels_tvalid[k]          = want_p[k];
                bus.s_axis_pixels_tdata[k*64 +: 64]  = {$urandom, $urandom};
                bus.s_axis_pixels_tuser[k*8 +: 8]    = (k == 0) ? pu0 : pu1;
            end
        end
        if (!(bus.s_axis_weights_tvalid && !acc_w)) begin
            for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
            bus.s_axis_weights_tvalid = want_w;
            bus.s_axis_weights_tdata  = v;
            bus.s_axis_weights_tuser  = wu;
            bus.s_axis_weights_tlast  = 1'($urandom_range(0, 1));
        end
        bus.m_axis_tready = mrdy;
        @(negedge aclk);
        acc_p = bus.s_axis_pixels_tvalid & bus.s_axis_pixels_tready;
        acc_w = bus.s_axis_weights_tvalid & bus.s_axis_weights_tready;
        @(posedge aclk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick(2'b00, 1'b0, 1'b1, 8'h05, 8'h05, 8'h00);
    endtask

    // Observes handshakes at the falling edge (values there are what the next
    // rising edge captures) and checks joined beats against the model.
    task automatic monitor();
        logic         prev_v = 1'b0;
        logic         prev_r = 1'b0;
        logic [401:0] prev_o = '0;
        logic [401:0] cur_o;
        beat_t        b;
        wt_t          w;
        pix_t         p0;
        pix_t         p1;
        forever begin
            @(negedge aclk);
            if (areset) begin
                pq0.delete(); pq1.delete(); wq.delete(); expq.delete();
                err_model = 1'b0;
                prev_v    = 1'b0;
                continue;
            end
            if (bus.s_axis_pixels_tvalid[0] && bus.s_axis_pixels_tready[0])
                pq0.push_back({bus.s_axis_pixels_tdata[63:0], bus.s_axis_pixels_tuser[7:0]});
            if (bus.s_axis_pixels_tvalid[1] && bus.s_axis_pixels_tready[1])
                pq1.push_back({bus.s_axis_pixels_tdata[127:64], bus.s_axis_pixels_tuser[15:8]});
            if (bus.s_axis_weights_tvalid && bus.s_axis_weights_tready)
                wq.push_back({bus.s_axis_weights_tdata, bus.s_axis_weights_tuser,
                              bus.s_axis_weights_tlast});
            while (wq.size() > 0 && (wq[0].u[3] || (pq0.size() > 0 && pq1.size() > 0))) begin
                w = wq.pop_front();
                if (w.u[3]) begin
                    b.pd = '0;
                    b.tu = {w.u, 8'h00};
                end else begin
                    p0 = pq0.pop_front();
                    p1 = pq1.pop_front();
                    b.pd = {p1.d, p0.d};
                    b.tu = {w.u, p0.u};
                    if (p1.u != p0.u) err_model = 1'b1;
                end
                b.wd  = w.d;
                b.l   = w.l;
                b.err = err_model;
                expq.push_back(b);
            end
            cur_o = {bus.m_axis_tvalid, bus.m_axis_pixels_tdata, bus.m_axis_weights_tdata,
                     bus.m_axis_tuser, bus.m_axis_tlast};
            if (prev_v && !prev_r) chk("hold_stable", cur_o, prev_o);
            if (!bus.m_axis_tvalid) chk("tuser_gate", bus.m_axis_tuser[15:8] & MASK, 8'h00);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    b = expq.pop_front();
                    chk("beat_pix", bus.m_axis_pixels_tdata, b.pd);
                    chk("beat_wts", bus.m_axis_weights_tdata, b.wd);
                    chk("beat_user", bus.m_axis_tuser, b.tu);
                    chk("beat_last", bus.m_axis_tlast, b.l);
                    chk("beat_err", err, b.err);
                end
            end
            prev_v = bus.m_axis_tvalid;
            prev_r = bus.m_axis_tready;
            prev_o = cur_o;
        end
    endtask

    initial begin
        int   n;
        logic cfg;
        areset                    = 1'b1;
        acc_p                     = 2'b00;
        acc_w                     = 1'b0;
        err_model                 = 1'b0;
        bus.s_axis_pixels_tvalid  = '0;
        bus.s_axis_pixels_tdata   = '0;
        bus.s_axis_pixels_tuser   = '0;
        bus.s_axis_weights_tvalid = 1'b0;
        bus.s_axis_weights_tdata  = '0;
        bus.s_axis_weights_tuser  = '0;
        bus.s_axis_weights_tlast  = 1'b0;
        bus.m_axis_tready         = 1'b0;
        fork monitor(); join_none

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_pix_rdy", bus.s_axis_pixels_tready, 2'b00);
        chk("rst_w_rdy", bus.s_axis_weights_tready, 1'b0);
        chk("rst_valid", bus.m_axis_tvalid, 1'b0);
        chk("rst_pdata", bus.m_axis_pixels_tdata, '0);
        chk("rst_wdata", bus.m_axis_weights_tdata, '0);
        chk("rst_user", bus.m_axis_tuser, '0);
        chk("rst_last", bus.m_axis_tlast, 1'b0);
        chk("rst_err", err, 1'b0);
        areset = 1'b0;
        settle(1);
        chk("rdy_after_rst", {bus.s_axis_weights_tready, bus.s_axis_pixels_tready}, 3'b111);

        // first-beat latency and full throughput
        tick(2'b11, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00);
        chk("lat_edge_e", bus.m_axis_tvalid, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(2'b11, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00);
            chk("throughput", bus.m_axis_tvalid, 1'b1);
        end
        settle(8);

        // copy 1 late: copy 0 fills its FIFO, no output until copy 1 arrives
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(2'b01, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00);
            if (acc_p[0]) n++;
        end
        chk("late_accepts", n, 4);
        chk("late_rdy0", bus.s_axis_pixels_tready[0], 1'b0);
        chk("late_no_out", bus.m_axis_tvalid, 1'b0);
        for (int i = 0; i < 12; i++) tick(2'b11, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00);
        settle(10);

        // output stalled for 10 cycles
        for (int i = 0; i < 10; i++) tick(2'b11, 1'b1, 1'b0, 8'h05, 8'h05, 8'h00);
        chk("stall_rdy", {bus.s_axis_weights_tready, bus.s_axis_pixels_tready}, 3'b000);
        chk("stall_valid", bus.m_axis_tvalid, 1'b1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.m_axis_tvalid) n++;
            tick(2'b00, 1'b0, 1'b1, 8'h05, 8'h05, 8'h00);
        end
        chk("stall_drain5", n, 5);
        settle(12);

        // config beat bypasses idle pixel streams
        tick(2'b00, 1'b1, 1'b1, 8'h05, 8'h05, 8'h08);
        settle(4);
        tick(2'b11, 1'b1, 1'b1, 8'h05, 8'h05, 8'h00);
        settle(4);

        // cross-copy tuser mismatch
        chk("err_before", err, 1'b0);
        tick(2'b11, 1'b1, 1'b1, 8'h05, 8'h06, 8'h00);
        tick(2'b00, 1'b0, 1'b1, 8'h05, 8'h05, 8'h00);
        chk("err_set", err, 1'b1);
        settle(5);
        chk("err_sticky", err, 1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cfg = ($urandom_range(0, 5) == 0);
            tick({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 8'h05, ($urandom_range(0, 31) == 0) ? 8'h06 : 8'h05,
                 (8'($urandom) & 8'hF7) | {4'h0, cfg, 3'b000});
        end
        for (int i = 0; i < 200 && (expq.size() != 0 || bus.s_axis_pixels_tvalid != 0
                                    || bus.s_axis_weights_tvalid); i++)
            settle(1);
        chk("drain_empty", expq.size(), 0);

        // reset with beats buffered
        settle(4);
        for (int i = 0; i < 3; i++) tick(2'b11, 1'b1, 1'b0, 8'h05, 8'h05, 8'h00);
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.m_axis_tvalid, 1'b0);
        chk("mid_rst_rdy", {bus.s_axis_weights_tready, bus.s_axis_pixels_tready}, 3'b000);
        chk("mid_rst_err", err, 1'b0);
        bus.s_axis_pixels_tvalid  = '0;
        bus.s_axis_weights_tvalid = 1'b0;
        acc_p = 2'b00;
        acc_w = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
`ifdef AXIS_INPUT_SYNC_STALL_COUNTERS_EN
        chk("cnt_rst", stall_count, '0);
`endif
        n = 0;
        for (int i = 0; i < 10; i++) begin
            settle(1);
            if (bus.m_axis_tvalid) n++;
        end
        chk("no_stale_beat", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
